byte_serial_lsu: RTL

Load/store initiator that drives a byte-wide data memory port on behalf of the core. It accepts one word, half or byte request per valid/ready handshake and serialises it into 1/2/4 single-byte memory cycles. Reads are assembled and sign- or zero-extended using the datamem flag encodings and endianness convention. It sits between the core's execute stage and a byte-addressed memory with combinational read and clocked write.

---
 rtl/datamem_pkg.sv | 43 ++++
 rtl/load_extend.sv | 27 ++
 rtl/byte_serial_lsu.sv | 132 +++++++++++++
 3 files changed

// File: rtl/datamem_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// datamem_pkg : shared LSU state, access-flag encodings and helpers
// Rev 1.0
// ------------------------------------------------------------------
package datamem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsuState_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;

  function automatic logic is_illegal(input logic write, input logic [2:0] flagsForReading,
                                      input logic [1:0] flagsForWriting);
    if (write) return (flagsForWriting == 2'b11);
    return (flagsForReading == 3'b011) || (flagsForReading[2:1] == 2'b11);
  endfunction

  // Low two bits of either code give the access size: 00 byte, 01 half, 10 word.
  function automatic logic [2:0] bytes_for_flags(input logic write, input logic [2:0] flagsForReading,
                                                 input logic [1:0] flagsForWriting);
    logic [1:0] size;
    size = write ? flagsForWriting : flagsForReading[1:0];
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ------------------------------------------------------------------
// load_extend : sign/zero extension of an assembled load value
// Rev 1.0
// ------------------------------------------------------------------
module load_extend
  import datamem_pkg::*;
(
  input  logic [31:0] assembly,
  input  logic [2:0]  flagsForReading,
  output logic [31:0] extended
);

  always_comb begin
    extended = 32'h0;
    case (flagsForReading)
      LB:      extended = {{24{assembly[7]}}, assembly[7:0]};
      LH:      extended = {{16{assembly[15]}}, assembly[15:0]};
      LW:      extended = assembly;
      LBU:     extended = {24'h0, assembly[7:0]};
      LHU:     extended = {16'h0, assembly[15:0]};
      default: extended = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/byte_serial_lsu.sv
`default_nettype none
// ------------------------------------------------------------------
// byte_serial_lsu : serialises word/half/byte requests onto a byte port
// Rev 1.0
// ------------------------------------------------------------------
module byte_serial_lsu
  import datamem_pkg::*;
#(
  parameter int ENDIANNESS = 1,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [ADDR_WIDTH-1:0] reqAddress,
  input  logic [2:0]            reqFlagsForReading,
  input  logic [1:0]            reqFlagsForWriting,
  input  logic [31:0]           reqValueForWriting,
  output logic                  respValid,
  output logic [31:0]           respValue,
  output logic                  respError,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic                  memWriteEnable,
  output logic [7:0]            memWriteByte,
  input  logic [7:0]            memReadByte,
  output logic                  busy
);

  lsuState_t             r_state;
  lsuState_t             w_nextState;
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  r_write;
  logic [2:0]            r_flagsForReading;
  logic [31:0]           r_data;
  logic [2:0]            r_numBytes;
  logic [1:0]            r_idx;
  logic [31:0]           r_assembly;
  logic                  r_error;

  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_lastByte;
  logic [1:0]            w_lane;
  logic [31:0]           w_extended;

  assign w_accept   = reqValid && (r_state == IDLE);
  assign w_illegal  = is_illegal(reqWrite, reqFlagsForReading, reqFlagsForWriting);
  assign w_lastByte = ({1'b0, r_idx} == (r_numBytes - 3'd1));

  generate
    if (ENDIANNESS == 1) begin : g_little
      assign w_lane = r_idx;
    end else begin : g_big
      logic [2:0] w_laneFull;
      assign w_laneFull = r_numBytes - 3'd1 - {1'b0, r_idx};
      assign w_lane     = w_laneFull[1:0];
    end
  endgenerate

  load_extend u_loadExtend (
    .assembly        (r_assembly),
    .flagsForReading (r_flagsForReading),
    .extended        (w_extended)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (reqValid) w_nextState = w_illegal ? DONE : ACCESS;
      ACCESS:  if (w_lastByte) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Every output is decoded from state so an async reset clears them at once.
  always_comb begin
    reqReady       = (r_state == IDLE);
    busy           = (r_state != IDLE);
    respValid      = (r_state == DONE);
    respError      = (r_state == DONE) && r_error;
    respValue      = 32'h0;
    memAddress     = '0;
    memWriteEnable = 1'b0;
    memWriteByte   = 8'h00;
    if (r_state == ACCESS) begin
      memAddress = r_base + {{(ADDR_WIDTH-2){1'b0}}, r_idx};
      if (r_write) begin
        memWriteEnable = 1'b1;
        memWriteByte   = r_data[{w_lane, 3'b000} +: 8];
      end
    end
    if ((r_state == DONE) && !r_write && !r_error) respValue = w_extended;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_base            <= '0;
      r_write           <= 1'b0;
      r_flagsForReading <= 3'b000;
      r_data            <= 32'h0;
      r_numBytes        <= 3'd0;
      r_idx             <= 2'd0;
      r_assembly        <= 32'h0;
      r_error           <= 1'b0;
    end else if (w_accept) begin
      r_base            <= reqAddress;
      r_write           <= reqWrite;
      r_flagsForReading <= reqFlagsForReading;
      r_data            <= reqValueForWriting;
      r_numBytes        <= bytes_for_flags(reqWrite, reqFlagsForReading, reqFlagsForWriting);
      r_idx             <= 2'd0;
      r_assembly        <= 32'h0;
      r_error           <= w_illegal;
    end else if (r_state == ACCESS) begin
      if (!r_write) r_assembly[{w_lane, 3'b000} +: 8] <= memReadByte;
      r_idx <= r_idx + 2'd1;
    end
  end

endmodule
`default_nettype wire
